// File: rtl/dmac_channel_ctrl.sv
// Control FSM for one DMA channel: loads the channel configuration, then alternates
// AHB read bursts (source -> FIFO) and write bursts (FIFO -> destination) until size is zero.
module dmac_channel_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_en,
  input  logic       hready,
  input  logic       hresp,
  input  logic       bs0,
  input  logic       tslb,
  input  logic       ts0,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       s_sel,
  output logic       d_sel,
  output logic       t_sel,
  output logic       b_sel,
  output logic       s_en,
  output logic       d_en,
  output logic       ts_en,
  output logic       sz_en,
  output logic       burst_en,
  output logic       count_en,
  output logic       h_sel,
  output logic       wr_en,
  output logic       rd_en,
  output logic       trigger,
  output logic [1:0] htrans,
  output logic       hwrite,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, LOAD, DECIDE, PRIME, READ, RD_DRAIN, WRITE, WR_DRAIN, DONE, ERR
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t state, next_state;
  logic   ch_en_q;
  logic   pend_rd, pend_wr;
  logic   first_beat;
  logic   pending, data_err, data_done, abort, issue, accept;

  assign pending   = pend_rd | pend_wr;
  assign data_err  = pending & hready & hresp;
  // True when no data phase is outstanding past this cycle.
  assign data_done = ~pending | hready;
  assign abort     = ~ch_en & (state != IDLE) & (state != ERR);

  // Address-phase request; an error or abort suppresses any new address immediately.
  assign issue  = ~abort & ~data_err &
                  (((state == READ) & ~fifo_full) |
                   ((state == WRITE) & (~fifo_empty | pending)));
  assign accept = issue & hready;

  assign htrans  = issue ? (first_beat ? HT_NONSEQ : HT_SEQ) : HT_IDLE;
  assign hwrite  = (state == WRITE);
  assign h_sel   = (state == WRITE);
  assign wr_en   = pend_rd & hready & ~hresp;
  assign rd_en   = pend_wr & hready & ~hresp;
  assign trigger = pend_wr;
  assign busy    = (state != IDLE) & (state != DONE) & (state != ERR);
  assign err     = (state == ERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch_en_q    <= 1'b0;
      pend_rd    <= 1'b0;
      pend_wr    <= 1'b0;
      first_beat <= 1'b0;
    end else begin
      state   <= next_state;
      ch_en_q <= ch_en;
      if (accept) begin
        pend_rd <= (state == READ);
        pend_wr <= (state == WRITE);
      end else if (hready) begin
        pend_rd <= 1'b0;
        pend_wr <= 1'b0;
      end
      if ((next_state != state) && ((next_state == READ) || (next_state == WRITE)))
        first_beat <= 1'b1;
      else if (accept)
        first_beat <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    s_sel      = 1'b0;
    d_sel      = 1'b0;
    t_sel      = 1'b0;
    b_sel      = 1'b0;
    s_en       = 1'b0;
    d_en       = 1'b0;
    ts_en      = 1'b0;
    sz_en      = 1'b0;
    burst_en   = 1'b0;
    count_en   = 1'b0;
    done       = 1'b0;

    if (data_err) begin
      next_state = ERR;
    end else if (abort) begin
      // Let the outstanding data phase finish, then drop back without a done pulse.
      if (data_done) next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: if (ch_en && !ch_en_q) next_state = LOAD;
        LOAD: begin
          s_sel      = 1'b1;
          d_sel      = 1'b1;
          t_sel      = 1'b1;
          s_en       = 1'b1;
          d_en       = 1'b1;
          ts_en      = 1'b1;
          sz_en      = 1'b1;
          burst_en   = 1'b1;
          next_state = DECIDE;
        end
        DECIDE: begin
          if (ts0) begin
            next_state = DONE;
          end else begin
            if (tslb) begin
              burst_en = 1'b1;
              b_sel    = 1'b1;
            end
            next_state = PRIME;
          end
        end
        PRIME: begin
          count_en   = 1'b1;
          next_state = READ;
        end
        READ: begin
          if (accept) begin
            s_en     = 1'b1;
            count_en = 1'b1;
            if (bs0) next_state = RD_DRAIN;
          end
        end
        RD_DRAIN: if (data_done) next_state = WRITE;
        WRITE: begin
          if (accept) begin
            d_en     = 1'b1;
            count_en = ~bs0;
            if (bs0) begin
              ts_en      = 1'b1;
              next_state = WR_DRAIN;
            end
          end
        end
        WR_DRAIN: if (data_done) next_state = DECIDE;
        DONE: begin
          done       = 1'b1;
          next_state = IDLE;
        end
        ERR: if (!ch_en) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

endmodule
